// File: rtl/rx_sync_pkg.sv
// rtl/rx_sync_pkg.sv - shared state encoding, parameter defaults and counter helper for rx sync
package rx_sync_pkg;

    localparam int SYM_BITS_DEF      = 10;
    localparam int LOCK_COUNT_DEF    = 3;
    localparam int ERR_LIMIT_DEF     = 4;
    localparam int COMMA_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        S_HUNT   = 2'b00,
        S_VERIFY = 2'b01,
        S_LOCKED = 2'b10
    } sync_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rx_phase_counter.sv
// rtl/rx_phase_counter.sv - modulo-SYM_BITS bit phase counter with realign load and symbol strobe
module rx_phase_counter #(
    parameter int SYM_BITS = 10,
    parameter int PW       = $clog2(SYM_BITS)
) (
    input  logic          i_bit_clk,
    input  logic          i_reset_n,
    input  logic          i_realign,
    input  logic          i_strobe_en,
    output logic [PW-1:0] o_phase,
    output logic          o_sym_strobe
);

    localparam logic [PW-1:0] LAST = PW'(SYM_BITS - 1);

    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_next;
    logic          r_sym_strobe;

    // The comma cycle itself is phase 0, so a realign lands on phase 1.
    always_comb begin
        w_phase_next = r_phase + PW'(1);
        if (i_realign) begin
            w_phase_next = PW'(1);
        end else if (r_phase == LAST) begin
            w_phase_next = '0;
        end
    end

    always_ff @(posedge i_bit_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_phase      <= '0;
            r_sym_strobe <= 1'b0;
        end else begin
            r_phase      <= w_phase_next;
            r_sym_strobe <= i_strobe_en && (w_phase_next == LAST);
        end
    end

    assign o_phase      = r_phase;
    assign o_sym_strobe = r_sym_strobe;

endmodule

// File: rtl/rx_sync_controller.sv
// rtl/rx_sync_controller.sv - comma-based symbol alignment FSM (HUNT/VERIFY/LOCKED)
module rx_sync_controller
    import rx_sync_pkg::*;
#(
    parameter int SYM_BITS      = SYM_BITS_DEF,
    parameter int LOCK_COUNT    = LOCK_COUNT_DEF,
    parameter int ERR_LIMIT     = ERR_LIMIT_DEF,
    parameter int COMMA_TIMEOUT = COMMA_TIMEOUT_DEF
) (
    input  logic       BitCLK,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Comma,
    output logic       SymStrobe,
    output logic       Locked,
    output logic       AlignErr,
    output logic [1:0] SyncState
);

    localparam int         PW        = $clog2(SYM_BITS);
    localparam logic [7:0] LOCK_CNT8 = 8'(LOCK_COUNT);
    localparam logic [7:0] ERR_LIM8  = 8'(ERR_LIMIT);
    localparam logic [7:0] TMO8      = 8'(COMMA_TIMEOUT);

    sync_state_t   r_state;
    sync_state_t   w_state_next;
    logic [7:0]    r_good;
    logic [7:0]    r_err;
    logic [7:0]    r_timer;
    logic [7:0]    w_good_next;
    logic [7:0]    w_err_next;
    logic [7:0]    w_timer_next;
    logic          r_debounce;
    logic          w_debounce_next;
    logic          r_align_err;
    logic          r_locked;
    logic          w_err_pulse;
    logic          w_realign;
    logic          w_strobe_en;
    logic [PW-1:0] w_phase;
    logic          w_sym_strobe;
    logic          w_comma_ok;
    logic          w_aligned;
    logic          w_misaligned;
    logic          w_timeout;

    assign w_comma_ok   = Comma && !r_debounce;
    assign w_aligned    = w_comma_ok && (w_phase == '0);
    assign w_misaligned = w_comma_ok && (w_phase != '0);
    assign w_timeout    = (r_timer == TMO8);
    assign w_strobe_en  = (w_state_next != S_HUNT);

    rx_phase_counter #(
        .SYM_BITS (SYM_BITS),
        .PW       (PW)
    ) u_phase (
        .i_bit_clk    (BitCLK),
        .i_reset_n    (Reset),
        .i_realign    (w_realign),
        .i_strobe_en  (w_strobe_en),
        .o_phase      (w_phase),
        .o_sym_strobe (w_sym_strobe)
    );

    always_comb begin
        w_state_next    = r_state;
        w_good_next     = r_good;
        w_err_next      = r_err;
        w_timer_next    = w_sym_strobe ? sat_inc(r_timer, TMO8) : r_timer;
        w_realign       = 1'b0;
        w_err_pulse     = 1'b0;
        w_debounce_next = 1'b0;

        case (r_state)
            S_HUNT: begin
                w_good_next  = 8'd0;
                w_err_next   = 8'd0;
                w_timer_next = 8'd0;
                if (w_comma_ok) begin
                    w_realign       = 1'b1;
                    w_good_next     = 8'd1;
                    w_debounce_next = 1'b1;
                    w_state_next    = (LOCK_COUNT == 1) ? S_LOCKED : S_VERIFY;
                end
            end
            S_VERIFY: begin
                if (w_aligned) begin
                    w_good_next     = sat_inc(r_good, LOCK_CNT8);
                    w_timer_next    = 8'd0;
                    w_debounce_next = 1'b1;
                    if (w_good_next >= LOCK_CNT8) begin
                        w_state_next = S_LOCKED;
                        w_err_next   = 8'd0;
                    end
                end else if (w_misaligned) begin
                    w_realign       = 1'b1;
                    w_good_next     = 8'd1;
                    w_timer_next    = 8'd0;
                    w_debounce_next = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = S_HUNT;
                end
            end
            S_LOCKED: begin
                if (w_aligned) begin
                    w_err_next      = 8'd0;
                    w_timer_next    = 8'd0;
                    w_debounce_next = 1'b1;
                end else if (w_misaligned || w_timeout) begin
                    // A coincident misaligned comma and timeout is one error.
                    w_err_pulse = 1'b1;
                    w_err_next  = sat_inc(r_err, ERR_LIM8);
                    if (w_timeout) begin
                        w_timer_next = 8'd0;
                    end
                    if (w_err_next >= ERR_LIM8) begin
                        w_state_next = S_HUNT;
                    end
                end
            end
            default: begin
                w_state_next = S_HUNT;
            end
        endcase

        if (!Enable) begin
            w_state_next    = S_HUNT;
            w_good_next     = 8'd0;
            w_err_next      = 8'd0;
            w_timer_next    = 8'd0;
            w_realign       = 1'b0;
            w_err_pulse     = 1'b0;
            w_debounce_next = 1'b0;
        end
    end

    always_ff @(posedge BitCLK or negedge Reset) begin
        if (!Reset) begin
            r_state     <= S_HUNT;
            r_good      <= 8'd0;
            r_err       <= 8'd0;
            r_timer     <= 8'd0;
            r_debounce  <= 1'b0;
            r_align_err <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_good      <= w_good_next;
            r_err       <= w_err_next;
            r_timer     <= w_timer_next;
            r_debounce  <= w_debounce_next;
            r_align_err <= w_err_pulse;
            r_locked    <= (w_state_next == S_LOCKED);
        end
    end

    assign SymStrobe = w_sym_strobe;
    assign Locked    = r_locked;
    assign AlignErr  = r_align_err;
    assign SyncState = r_state;

endmodule
